// File: rtl/uart_tx_frame_engine.sv
// UART transmit framer: a single-word holding buffer feeding a tick-paced
// frame FSM that serialises START, DATA_W data bits (LSB first), an optional
// parity bit and one or two STOP bits onto a registered, idle-high line.
module uart_tx_frame_engine #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TX_TICK,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              DATA_VLD,
    output logic              DATA_RDY,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              STOP2,
    output logic              TX_OUT,
    output logic              BUSY,
    output logic              FRAME_DONE
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t              state_reg, state_next;

    // Holding buffer: the word plus its per-frame configuration.
    logic [DATA_W-1:0]   hold_data_reg, hold_data_next;
    logic                hold_par_en_reg, hold_par_en_next;
    logic                hold_par_typ_reg, hold_par_typ_next;
    logic                hold_stop2_reg, hold_stop2_next;
    logic                hold_full_reg, hold_full_next;

    // In-flight frame: shifter and the configuration latched with it.
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic                frame_par_en_reg, frame_par_en_next;
    logic                frame_parity_reg, frame_parity_next;
    logic                frame_stop2_reg, frame_stop2_next;
    logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic                stop_cnt_reg, stop_cnt_next;

    logic                tx_out_reg, tx_out_next;
    logic                frame_done_reg, frame_done_next;
    logic                load_frame;

    // Next-state logic: buffer accept, tick-paced frame FSM and line value.
    always_comb begin
        state_next        = state_reg;
        hold_data_next    = hold_data_reg;
        hold_par_en_next  = hold_par_en_reg;
        hold_par_typ_next = hold_par_typ_reg;
        hold_stop2_next   = hold_stop2_reg;
        hold_full_next    = hold_full_reg;
        shift_next        = shift_reg;
        frame_par_en_next = frame_par_en_reg;
        frame_parity_next = frame_parity_reg;
        frame_stop2_next  = frame_stop2_reg;
        bit_cnt_next      = bit_cnt_reg;
        stop_cnt_next     = stop_cnt_reg;
        tx_out_next       = tx_out_reg;
        frame_done_next   = 1'b0;
        load_frame        = 1'b0;

        // Accept only into an empty buffer; a full buffer is never overwritten.
        if (DATA_VLD && !hold_full_reg) begin
            hold_data_next    = P_DATA;
            hold_par_en_next  = PAR_EN;
            hold_par_typ_next = PAR_TYP;
            hold_stop2_next   = STOP2;
            hold_full_next    = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (TX_TICK && hold_full_reg) begin
                    load_frame = 1'b1;
                end
            end
            ST_START: begin
                if (TX_TICK) begin
                    state_next  = ST_DATA;
                    tx_out_next = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (TX_TICK) begin
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        if (frame_par_en_reg) begin
                            state_next  = ST_PARITY;
                            tx_out_next = frame_parity_reg;
                        end else begin
                            state_next    = ST_STOP;
                            tx_out_next   = 1'b1;
                            stop_cnt_next = 1'b0;
                        end
                    end else begin
                        tx_out_next = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (TX_TICK) begin
                    state_next    = ST_STOP;
                    tx_out_next   = 1'b1;
                    stop_cnt_next = 1'b0;
                end
            end
            ST_STOP: begin
                if (TX_TICK) begin
                    if (frame_stop2_reg && (stop_cnt_reg == 1'b0)) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        frame_done_next = 1'b1;
                        if (hold_full_reg) begin
                            // Back-to-back: next START directly after the last stop bit.
                            load_frame = 1'b1;
                        end else begin
                            state_next  = ST_IDLE;
                            tx_out_next = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next  = ST_IDLE;
                tx_out_next = 1'b1;
            end
        endcase

        // Move the buffered word into the shifter and begin its START bit.
        if (load_frame) begin
            state_next        = ST_START;
            tx_out_next       = 1'b0;
            shift_next        = hold_data_reg;
            frame_par_en_next = hold_par_en_reg;
            frame_parity_next = (^hold_data_reg) ^ hold_par_typ_reg;
            frame_stop2_next  = hold_stop2_reg;
            hold_full_next    = 1'b0;
            bit_cnt_next      = '0;
            stop_cnt_next     = 1'b0;
        end
    end

    // State register; reset aborts any frame and returns the line high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg        <= ST_IDLE;
            hold_data_reg    <= '0;
            hold_par_en_reg  <= 1'b0;
            hold_par_typ_reg <= 1'b0;
            hold_stop2_reg   <= 1'b0;
            hold_full_reg    <= 1'b0;
            shift_reg        <= '0;
            frame_par_en_reg <= 1'b0;
            frame_parity_reg <= 1'b0;
            frame_stop2_reg  <= 1'b0;
            bit_cnt_reg      <= '0;
            stop_cnt_reg     <= 1'b0;
            tx_out_reg       <= 1'b1;
            frame_done_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            hold_data_reg    <= hold_data_next;
            hold_par_en_reg  <= hold_par_en_next;
            hold_par_typ_reg <= hold_par_typ_next;
            hold_stop2_reg   <= hold_stop2_next;
            hold_full_reg    <= hold_full_next;
            shift_reg        <= shift_next;
            frame_par_en_reg <= frame_par_en_next;
            frame_parity_reg <= frame_parity_next;
            frame_stop2_reg  <= frame_stop2_next;
            bit_cnt_reg      <= bit_cnt_next;
            stop_cnt_reg     <= stop_cnt_next;
            tx_out_reg       <= tx_out_next;
            frame_done_reg   <= frame_done_next;
        end
    end

    assign DATA_RDY   = ~hold_full_reg;
    assign BUSY       = (state_reg != ST_IDLE) | hold_full_reg;
    assign TX_OUT     = tx_out_reg;
    assign FRAME_DONE = frame_done_reg;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Bench for uart_tx_frame_engine: table of known frames, hand-written corner
// sequences and randomized frames compared with a bit-list model of a frame.
module tb_uart_tx_frame_engine;

    localparam int DATA_W = 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              TX_TICK = 1'b0;
    logic [DATA_W-1:0] P_DATA = '0;
    logic              DATA_VLD = 1'b0;
    logic              PAR_EN = 1'b0;
    logic              PAR_TYP = 1'b0;
    logic              STOP2 = 1'b0;
    logic              DATA_RDY;
    logic              TX_OUT;
    logic              BUSY;
    logic              FRAME_DONE;

    int   errors = 0;
    int   checks = 0;
    int   tick_period = 4;
    int   tick_cnt = 0;
    int   fd_count = 0;
    logic line_q[$];

    uart_tx_frame_engine #(.DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST(RST), .TX_TICK(TX_TICK), .P_DATA(P_DATA),
        .DATA_VLD(DATA_VLD), .DATA_RDY(DATA_RDY), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .STOP2(STOP2), .TX_OUT(TX_OUT), .BUSY(BUSY),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    // Baud tick: one-cycle pulse every tick_period clocks, driven on the falling edge.
    initial forever begin
        @(negedge CLK);
        tick_cnt++;
        if (tick_cnt >= tick_period) begin
            TX_TICK  = 1'b1;
            tick_cnt = 0;
        end else begin
            TX_TICK = 1'b0;
        end
    end

    // Line monitor: one sample of TX_OUT just after every ticked edge.
    initial forever begin
        @(posedge CLK);
        if (TX_TICK) begin
            #1;
            line_q.push_back(TX_OUT);
        end
    end

    // FRAME_DONE pulse counter.
    initial forever begin
        @(negedge CLK);
        if (FRAME_DONE === 1'b1) fd_count++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic [7:0]  word;
        logic        pe;
        logic        pt;
        logic        s2;
        logic [4:0]  period;
        logic [3:0]  len;
        logic [15:0] line;   // line bits, first bit is the leftmost of len bits
    } vec_t;

    function automatic vec_t mk_vec(logic [7:0] w, logic pe, logic pt, logic s2,
                                    int per, int len, logic [15:0] line);
        vec_t v;
        v.word = w; v.pe = pe; v.pt = pt; v.s2 = s2;
        v.period = 5'(per); v.len = 4'(len); v.line = line;
        return v;
    endfunction

    function automatic string vec_line(logic [15:0] line, int len);
        string s = "";
        for (int i = 0; i < len; i++) s = {s, line[len-1-i] ? "1" : "0"};
        return s;
    endfunction

    // Reference frame: start 0, data LSB first, parity making the ones count
    // even (or odd), then the stop bits.
    function automatic string model_frame(logic [7:0] w, logic pe, logic pt, logic s2);
        string s = "0";
        int    ones = 0;
        for (int i = 0; i < DATA_W; i++) begin
            s = {s, w[i] ? "1" : "0"};
            if (w[i]) ones++;
        end
        if (pe) s = {s, (((ones % 2) == 1) ^ pt) ? "1" : "0"};
        s = {s, "1"};
        if (s2) s = {s, "1"};
        return s;
    endfunction

    task automatic chk_bit(string name, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic chk_int(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic chk_str(string name, string got, string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %s want %s", name, got, exp);
        end
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // Offer a word until it is accepted, then scramble the inputs.
    task automatic push_word(logic [7:0] w, logic pe, logic pt, logic s2);
        int n = 0;
        P_DATA = w; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; DATA_VLD = 1'b1;
        while (DATA_RDY !== 1'b1 && n < 2000) begin
            @(posedge CLK); #2; n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL push_timeout: DATA_RDY got %b want 1", DATA_RDY);
        end
        @(posedge CLK); #2;
        DATA_VLD = 1'b0;
        P_DATA   = 8'($urandom);
        PAR_EN   = 1'($urandom_range(0, 1));
        PAR_TYP  = 1'($urandom_range(0, 1));
        STOP2    = 1'($urandom_range(0, 1));
    endtask

    // Skip idle ones up to a START bit, then collect nbits line samples.
    task automatic get_frame(input int nbits, output string s, output int idle, output bit ok);
        int waited = 0;
        bit found  = 0;
        s = ""; idle = 0; ok = 1;
        while (!found) begin
            while (line_q.size() == 0 && waited < 4000) begin
                @(posedge CLK); #2; waited++;
            end
            if (line_q.size() == 0) begin ok = 0; return; end
            if (line_q[0] == 1'b0) found = 1;
            else begin void'(line_q.pop_front()); idle++; end
        end
        for (int i = 0; i < nbits; i++) begin
            while (line_q.size() == 0 && waited < 4000) begin
                @(posedge CLK); #2; waited++;
            end
            if (line_q.size() == 0) begin ok = 0; return; end
            s = {s, line_q.pop_front() ? "1" : "0"};
        end
    endtask

    task automatic expect_frame(string name, logic [7:0] w, logic pe, logic pt, logic s2,
                                output int idle, output string got);
        string exp;
        bit    ok;
        exp = model_frame(w, pe, pt, s2);
        get_frame(exp.len(), got, idle, ok);
        if (!ok) got = {got, "<timeout>"};
        $display("tx %s word=%02h pe=%0d pt=%0d s2=%0d line=%s idle=%0d", name, w, pe, pt, s2, got, idle);
        chk_str({name, " model"}, got, exp);
    endtask

    task automatic wait_fd(int target);
        int n = 0;
        while (fd_count < target && n < 500) begin
            @(posedge CLK); #2; n++;
        end
    endtask

    vec_t  vecs[6];
    vec_t  v;
    string got;
    int    idle, fd0, n, zeros;
    logic  prev_tx;
    logic [7:0] w1, w2;
    logic  c1[3];
    logic  c2[3];
    bit    two;

    initial begin
        vecs[0] = mk_vec(8'hA5, 0, 0, 0, 16, 10, 16'b0101001011);
        vecs[1] = mk_vec(8'h03, 1, 0, 0, 4, 11, 16'b01100000001);
        vecs[2] = mk_vec(8'h03, 1, 1, 0, 4, 11, 16'b01100000011);
        vecs[3] = mk_vec(8'h07, 1, 0, 0, 4, 11, 16'b01110000011);
        vecs[4] = mk_vec(8'h80, 1, 1, 1, 4, 12, 16'b000000001011);
        vecs[5] = mk_vec(8'h5A, 0, 0, 1, 3, 11, 16'b00101101011);

        // Reset state
        RST = 1'b0;
        cycles(3);
        chk_bit("reset TX_OUT", TX_OUT, 1'b1);
        chk_bit("reset DATA_RDY", DATA_RDY, 1'b1);
        chk_bit("reset BUSY", BUSY, 1'b0);
        chk_bit("reset FRAME_DONE", FRAME_DONE, 1'b0);
        RST = 1'b1;
        cycles(2);

        // Table of known frames
        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            tick_period = int'(v.period);
            cycles(3 * tick_period);
            line_q.delete();
            fd0 = fd_count;
            push_word(v.word, v.pe, v.pt, v.s2);
            expect_frame($sformatf("vec%0d", k), v.word, v.pe, v.pt, v.s2, idle, got);
            chk_str($sformatf("vec%0d line", k), got, vec_line(v.line, int'(v.len)));
            wait_fd(fd0 + 1);
            cycles(2);
            chk_int($sformatf("vec%0d frame_done count", k), fd_count - fd0, 1);
            chk_bit($sformatf("vec%0d BUSY after", k), BUSY, 1'b0);
            chk_bit($sformatf("vec%0d TX_OUT after", k), TX_OUT, 1'b1);
        end

        // Back-to-back with two stop bits; DATA_RDY rises with the first START
        tick_period = 4;
        cycles(12);
        line_q.delete();
        fd0 = fd_count;
        push_word(8'h55, 0, 0, 1);
        n = 0;
        prev_tx = TX_OUT;
        while (DATA_RDY !== 1'b1 && n < 200) begin
            prev_tx = TX_OUT;
            @(posedge CLK); #2; n++;
        end
        chk_bit("b2b TX_OUT when DATA_RDY rises", TX_OUT, 1'b0);
        chk_bit("b2b TX_OUT cycle before", prev_tx, 1'b1);
        push_word(8'hAA, 0, 0, 1);
        expect_frame("b2b first", 8'h55, 0, 0, 1, idle, got);
        expect_frame("b2b second", 8'hAA, 0, 0, 1, idle, got);
        chk_int("b2b idle bits between frames", idle, 0);
        wait_fd(fd0 + 2);
        cycles(2);
        chk_int("b2b frame_done count", fd_count - fd0, 2);

        // Reset during data bit 3
        cycles(12);
        line_q.delete();
        push_word(8'hF0, 0, 0, 0);
        get_frame(5, got, idle, two);
        chk_str("reset mid-frame prefix", got, "00000");
        #1;
        chk_bit("TX_OUT before reset", TX_OUT, 1'b0);
        RST = 1'b0;
        #1;
        chk_bit("async reset TX_OUT", TX_OUT, 1'b1);
        chk_bit("async reset BUSY", BUSY, 1'b0);
        chk_bit("async reset DATA_RDY", DATA_RDY, 1'b1);
        cycles(2);
        RST = 1'b1;
        cycles(8);
        line_q.delete();
        fd0 = fd_count;
        push_word(8'h3C, 1, 1, 0);
        expect_frame("after reset", 8'h3C, 1, 1, 0, idle, got);
        wait_fd(fd0 + 1);
        cycles(2);
        chk_int("after reset frame_done count", fd_count - fd0, 1);

        // Full buffer is not overwritten; config toggling mid-frame is ignored
        cycles(12);
        line_q.delete();
        fd0 = fd_count;
        push_word(8'h11, 0, 0, 0);
        push_word(8'h22, 1, 0, 1);
        P_DATA = 8'h99; DATA_VLD = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            PAR_EN = ~PAR_EN; PAR_TYP = 1'($urandom_range(0, 1)); STOP2 = ~STOP2;
            @(posedge CLK); #2;
            if (DATA_RDY === 1'b1) n++;
        end
        DATA_VLD = 1'b0;
        chk_int("full buffer DATA_RDY high cycles", n, 0);
        expect_frame("hold first", 8'h11, 0, 0, 0, idle, got);
        expect_frame("hold second", 8'h22, 1, 0, 1, idle, got);
        chk_int("hold idle bits between frames", idle, 0);
        wait_fd(fd0 + 2);
        cycles(32);
        zeros = 0;
        foreach (line_q[i]) if (line_q[i] == 1'b0) zeros++;
        chk_int("no third frame", zeros, 0);
        chk_int("hold frame_done count", fd_count - fd0, 2);
        chk_bit("hold BUSY after", BUSY, 1'b0);

        // Accept on the same edge as an IDLE tick starts at the following tick
        cycles(8);
        line_q.delete();
        n = 0;
        while (TX_TICK !== 1'b1 && n < 50) begin
            @(posedge CLK); #2; n++;
        end
        cycles(tick_period - 1);
        P_DATA = 8'hC3; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; DATA_VLD = 1'b1;
        cycles(1);
        DATA_VLD = 1'b0;
        chk_bit("tick-accept DATA_RDY", DATA_RDY, 1'b0);
        chk_bit("tick-accept TX_OUT not yet started", TX_OUT, 1'b1);
        chk_bit("tick-accept BUSY", BUSY, 1'b1);
        n = 0;
        while (TX_OUT !== 1'b0 && n < 100) begin
            @(posedge CLK); #2; n++;
        end
        chk_int("tick-accept start latency", n, tick_period);
        expect_frame("tick-accept", 8'hC3, 0, 0, 0, idle, got);

        // Randomized frames, single or back-to-back pairs
        cycles(16);
        line_q.delete();
        for (int it = 0; it < 15; it++) begin
            tick_period = int'($urandom_range(2, 6));
            cycles(int'($urandom_range(0, 10)));
            w1 = 8'($urandom);
            w2 = 8'($urandom);
            for (int j = 0; j < 3; j++) begin
                c1[j] = 1'($urandom_range(0, 1));
                c2[j] = 1'($urandom_range(0, 1));
            end
            two = 1'($urandom_range(0, 1));
            push_word(w1, c1[0], c1[1], c1[2]);
            if (two) push_word(w2, c2[0], c2[1], c2[2]);
            expect_frame($sformatf("rand%0d a", it), w1, c1[0], c1[1], c1[2], idle, got);
            if (two) begin
                expect_frame($sformatf("rand%0d b", it), w2, c2[0], c2[1], c2[2], idle, got);
                chk_int($sformatf("rand%0d idle between", it), idle, 0);
            end
        end

        cycles(40);
        chk_bit("final BUSY", BUSY, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
